// File: rtl/usb3_descramble.sv
// USB 3.0 receive descrambler with SKP strip and 7-symbol repacking; 2-cycle latency.
// No backpressure: input is accepted every cycle; out_valid drops while fewer than 4 symbols are held.
module usb3_descramble #(
    parameter bit SKP_STRIP = 1'b1
) (
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_datak,
    output logic        out_valid,
    output logic [2:0]  skp_removed
);

    localparam logic [15:0] SEED    = 16'hFFFF;
    localparam logic [7:0]  SYM_COM = 8'hBC;
    localparam logic [7:0]  SYM_SKP = 8'h3C;

    // Galois form of x^16+x^5+x^4+x^3+1; key bits come out LSB first from lfsr[15]
    function automatic logic [7:0] lfsr_key(input logic [15:0] s);
        logic [15:0] t;
        logic [7:0]  k;
        t = s;
        k = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k[i] = t[15];
            t = {t[14:0], 1'b0} ^ (t[15] ? 16'h0039 : 16'h0000);
        end
        return k;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[14:0], 1'b0} ^ (t[15] ? 16'h0039 : 16'h0000);
        end
        return t;
    endfunction

    logic [31:0] s1_data;
    logic [3:0]  s1_datak;
    logic        s1_valid;
    logic        s1_en;

    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [7:0]  buf_dat [0:2];
    logic        buf_k   [0:2];
    logic [1:0]  buf_cnt;

    logic [7:0]  mrg_dat [0:7];
    logic        mrg_k   [0:7];
    logic [3:0]  fill;
    logic [2:0]  skp_cnt;
    logic        emit;

    always_comb begin
        logic [7:0] sym;
        logic [7:0] val;
        logic       symk;
        logic       keep;
        lfsr_nxt = lfsr;
        skp_cnt  = 3'd0;
        fill     = {2'b00, buf_cnt};
        sym      = 8'h00;
        val      = 8'h00;
        symk     = 1'b0;
        keep     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mrg_dat[i] = 8'h00;
            mrg_k[i]   = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            mrg_dat[i] = buf_dat[i];
            mrg_k[i]   = buf_k[i];
        end
        // Lane 3 is oldest, so walk downwards to keep LFSR order equal to wire order
        for (int lane = 3; lane >= 0; lane--) begin
            sym  = s1_data[lane*8 +: 8];
            symk = s1_datak[lane];
            val  = sym;
            keep = 1'b0;
            if (s1_valid) begin
                if (symk && sym == SYM_COM) begin
                    keep     = 1'b1;
                    lfsr_nxt = SEED;
                end else if (symk && sym == SYM_SKP) begin
                    keep = !SKP_STRIP;
                    if (SKP_STRIP) begin
                        skp_cnt = skp_cnt + 3'd1;
                    end
                end else if (symk) begin
                    keep     = 1'b1;
                    lfsr_nxt = lfsr_step(lfsr_nxt);
                end else begin
                    keep     = 1'b1;
                    val      = sym ^ lfsr_key(lfsr_nxt);
                    lfsr_nxt = lfsr_step(lfsr_nxt);
                end
            end
            if (keep) begin
                mrg_dat[fill[2:0]] = val;
                mrg_k[fill[2:0]]   = symk;
                fill               = fill + 4'd1;
            end
        end
        emit = (fill >= 4'd4);
    end

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            s1_data     <= 32'h0;
            s1_datak    <= 4'h0;
            s1_valid    <= 1'b0;
            s1_en       <= 1'b0;
            lfsr        <= SEED;
            buf_cnt     <= 2'd0;
            out_data    <= 32'h0;
            out_datak   <= 4'h0;
            out_valid   <= 1'b0;
            skp_removed <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                buf_dat[i] <= 8'h00;
                buf_k[i]   <= 1'b0;
            end
        end else begin
            s1_data  <= in_data;
            s1_datak <= in_datak;
            s1_valid <= in_valid;
            s1_en    <= enable;
            if (!s1_en) begin
                out_data    <= s1_data;
                out_datak   <= s1_datak;
                out_valid   <= s1_valid;
                skp_removed <= 3'd0;
                lfsr        <= SEED;
                buf_cnt     <= 2'd0;
            end else begin
                lfsr        <= lfsr_nxt;
                out_valid   <= emit;
                skp_removed <= skp_cnt;
                if (emit) begin
                    out_data  <= {mrg_dat[0], mrg_dat[1], mrg_dat[2], mrg_dat[3]};
                    out_datak <= {mrg_k[0], mrg_k[1], mrg_k[2], mrg_k[3]};
                    buf_cnt   <= 2'(fill - 4'd4);
                    for (int i = 0; i < 3; i++) begin
                        buf_dat[i] <= mrg_dat[i+4];
                        buf_k[i]   <= mrg_k[i+4];
                    end
                end else begin
                    buf_cnt <= fill[1:0];
                    for (int i = 0; i < 3; i++) begin
                        buf_dat[i] <= mrg_dat[i];
                        buf_k[i]   <= mrg_k[i];
                    end
                end
            end
        end
    end

endmodule
